// File: rtl/frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// frame_buf_pkg
// Definitions shared by the frame buffer memory arbiter and its sub-blocks.
//   - Polarity constants for active-low (_L) and active-high (_H) controls.
//   - Arbiter state encoding (IDLE / WRITE / READ).
//   - Grant encoding for the round-robin history (WR / RD).
// -----------------------------------------------------------------------------
package frame_buf_pkg;

   localparam logic ASSERT_L   = 1'b0;
   localparam logic DEASSERT_L = 1'b1;
   localparam logic ASSERT_H   = 1'b1;
   localparam logic DEASSERT_H = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } arb_state_t;

   typedef enum logic {
      WR = 1'b0,
      RD = 1'b1
   } grant_t;

   // Side that wins a tie: whichever did not hold the port last.
   function automatic grant_t opposite_grant(input grant_t g);
      return (g == WR) ? RD : WR;
   endfunction

endpackage : frame_buf_pkg

// File: rtl/frame_buf_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces around frame_buf_mem_arbiter.
//
// fb_mem_if  : frame buffer <-> arbiter.
//   master = frame buffer (drives wr_en/rd_en, addresses, write data)
//   slave  = arbiter      (drives wr_rdy/rd_rdy, rd_data, rd_data_valid)
//
// avl_mm_if  : arbiter <-> external memory Avalon-MM port.
//   master = arbiter (drives avl_write_req/avl_read_req, avl_addr, avl_wdata)
//   slave  = memory  (drives avl_ready, avl_rdata, avl_rdata_valid)
//
// Handshake rules:
//   wr_en/rd_en are active-low requests. A beat/command is transferred in any
//   cycle where the request is presented and the acceptor is ready: on the
//   memory side avl_*_req & avl_ready, mirrored back to the frame buffer as
//   wr_rdy/rd_rdy in the same cycle. The requester holds address and data
//   stable until it sees the matching ready. Read data returns later on
//   avl_rdata_valid with no back-pressure and is forwarded one cycle later
//   on rd_data_valid.
// -----------------------------------------------------------------------------
interface fb_mem_if #(
   parameter int ADDR_WIDTH = 29,
   parameter int DATA_WIDTH = 32
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_rdy;
   logic                  rd_rdy;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  wr_rdy, rd_rdy, rd_data, rd_data_valid
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output wr_rdy, rd_rdy, rd_data, rd_data_valid
   );
endinterface : fb_mem_if

interface avl_mm_if #(
   parameter int ADDR_WIDTH = 29,
   parameter int DATA_WIDTH = 32
);
   logic                  avl_ready;
   logic                  avl_write_req;
   logic                  avl_read_req;
   logic [ADDR_WIDTH-1:0] avl_addr;
   logic [DATA_WIDTH-1:0] avl_wdata;
   logic [DATA_WIDTH-1:0] avl_rdata;
   logic                  avl_rdata_valid;

   modport master (
      output avl_write_req, avl_read_req, avl_addr, avl_wdata,
      input  avl_ready, avl_rdata, avl_rdata_valid
   );

   modport slave (
      input  avl_write_req, avl_read_req, avl_addr, avl_wdata,
      output avl_ready, avl_rdata, avl_rdata_valid
   );
endinterface : avl_mm_if

// File: rtl/frame_buf_mem_arbiter_rd_credit_counter.sv
// -----------------------------------------------------------------------------
// rd_credit_counter
// Counts read commands in flight to the memory and raises a sticky underflow
// flag when a read return arrives that nothing is waiting for.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   issue_i       : a read command was accepted this cycle (+1)
//   return_i      : a read beat returned this cycle (-1)
//   count_o       : reads currently in flight
//   can_issue_o   : count below MAX_RD_OUTSTANDING
//   underflow_o   : sticky, set by a return with zero in flight; reset clears
// -----------------------------------------------------------------------------
module rd_credit_counter #(
   parameter int MAX_RD_OUTSTANDING = 16,
   parameter int CNT_WIDTH          = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_i,
   input  logic                 return_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic                 can_issue_o,
   output logic                 underflow_o
);

   localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(MAX_RD_OUTSTANDING);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 err_q, err_d;

   // Issue and return in the same cycle cancel out, even at zero, so that
   // case never counts as an underflow.
   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (issue_i && !return_i) begin
         count_d = count_q + CNT_ONE;
      end else if (!issue_i && return_i) begin
         if (count_q == '0) begin
            err_d = 1'b1;
         end else begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count_o     = count_q;
   assign can_issue_o = (count_q < LIMIT);
   assign underflow_o = err_q;

endmodule : rd_credit_counter

// File: rtl/frame_buf_mem_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buf_mem_arbiter
// Shares one Avalon-MM memory port between the frame buffer write channel
// (camera fill) and read channel (display drain). Round-robin grant with a
// burst quantum of BURST_LEN accepted beats per grant; per-beat ready back to
// the frame buffer; outstanding read tracking; registered read data return.
//
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   fb              : fb_mem_if.slave  (wr_en/rd_en active-low, addresses,
//                     wr_data in; wr_rdy/rd_rdy, rd_data, rd_data_valid out)
//   avl             : avl_mm_if.master (command/address/wdata out; ready,
//                     rdata, rdata_valid in)
//   rd_outstanding  : reads in flight
//   err_underflow   : sticky, read return seen with nothing outstanding
//   dbg_state       : current arbiter state
// -----------------------------------------------------------------------------
module frame_buf_mem_arbiter
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 29,
   parameter int BURST_LEN          = 8,
   parameter int MAX_RD_OUTSTANDING = 16,
   parameter int CNT_WIDTH          = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   fb_mem_if.slave              fb,
   avl_mm_if.master             avl,
   output logic [CNT_WIDTH-1:0] rd_outstanding,
   output logic                 err_underflow,
   output arb_state_t           dbg_state
);

   // quantum_q counts beats accepted earlier in the current grant, so the
   // accept that finds it at BURST_LEN-1 is the last one of the grant.
   localparam logic [CNT_WIDTH-1:0] QUANTUM_LAST = CNT_WIDTH'(BURST_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

   arb_state_t           state_q;
   grant_t               last_grant_q;
   logic [CNT_WIDTH-1:0] quantum_q;

   logic                  wr_req, rd_req, rd_can_issue;
   logic                  write_req_c, read_req_c;
   logic                  wr_accept, rd_accept;
   logic [ADDR_WIDTH-1:0] cmd_addr_c;
   logic [DATA_WIDTH-1:0] cmd_wdata_c;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_data_valid_q;

   // ---------------------------------------------------------------------
   // Eligibility. Reads are held back once the in-flight limit is reached.
   // ---------------------------------------------------------------------
   assign wr_req = (fb.wr_en == ASSERT_L);
   assign rd_req = (fb.rd_en == ASSERT_L) && rd_can_issue;

   // Commands follow the request combinationally while the side holds the
   // grant, so a stalled command (avl_ready low) keeps its address and data
   // exactly as the frame buffer holds them.
   assign write_req_c = (state_q == WRITE) && wr_req;
   assign read_req_c  = (state_q == READ)  && rd_req;
   assign wr_accept   = write_req_c && avl.avl_ready;
   assign rd_accept   = read_req_c  && avl.avl_ready;

   always_comb begin
      cmd_addr_c  = '0;
      cmd_wdata_c = '0;
      case (state_q)
         WRITE: begin
            cmd_addr_c  = fb.wr_addr;
            cmd_wdata_c = fb.wr_data;
         end
         READ: begin
            cmd_addr_c  = fb.rd_addr;
         end
         default: begin
            cmd_addr_c  = '0;
            cmd_wdata_c = '0;
         end
      endcase
   end

   assign avl.avl_write_req = write_req_c;
   assign avl.avl_read_req  = read_req_c;
   assign avl.avl_addr      = cmd_addr_c;
   assign avl.avl_wdata     = cmd_wdata_c;
   assign fb.wr_rdy         = wr_accept;
   assign fb.rd_rdy         = rd_accept;

   // ---------------------------------------------------------------------
   // Arbiter FSM. A grant always passes through IDLE, which costs one cycle
   // between grants but keeps the command path a pure decode of state_q.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= WR;
         quantum_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               quantum_q <= '0;
               if (wr_req && rd_req) begin
                  state_q <= (opposite_grant(last_grant_q) == RD) ? READ : WRITE;
               end else if (wr_req) begin
                  state_q <= WRITE;
               end else if (rd_req) begin
                  state_q <= READ;
               end
            end
            WRITE: begin
               if (!wr_req) begin
                  state_q      <= IDLE;
                  last_grant_q <= WR;
               end else if (wr_accept) begin
                  if (quantum_q == QUANTUM_LAST) begin
                     state_q      <= IDLE;
                     last_grant_q <= WR;
                  end else begin
                     quantum_q <= quantum_q + CNT_ONE;
                  end
               end
            end
            READ: begin
               // rd_req drops either on rd_en or on hitting the read limit;
               // both release the port.
               if (!rd_req) begin
                  state_q      <= IDLE;
                  last_grant_q <= RD;
               end else if (rd_accept) begin
                  if (quantum_q == QUANTUM_LAST) begin
                     state_q      <= IDLE;
                     last_grant_q <= RD;
                  end else begin
                     quantum_q <= quantum_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state_q;

   // ---------------------------------------------------------------------
   // Outstanding read tracking.
   // ---------------------------------------------------------------------
   rd_credit_counter #(
      .MAX_RD_OUTSTANDING (MAX_RD_OUTSTANDING),
      .CNT_WIDTH          (CNT_WIDTH)
   ) u_rd_credit (
      .clk         (clk),
      .reset       (reset),
      .issue_i     (rd_accept),
      .return_i    (avl.avl_rdata_valid),
      .count_o     (rd_outstanding),
      .can_issue_o (rd_can_issue),
      .underflow_o (err_underflow)
   );

   // ---------------------------------------------------------------------
   // Read return: one register stage, forwarded unconditionally (also for
   // unexpected returns that raise the underflow flag).
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q       <= '0;
         rd_data_valid_q <= DEASSERT_H;
      end else begin
         rd_data_q       <= avl.avl_rdata;
         rd_data_valid_q <= avl.avl_rdata_valid;
      end
   end

   assign fb.rd_data       = rd_data_q;
   assign fb.rd_data_valid = rd_data_valid_q;

endmodule : frame_buf_mem_arbiter
